// File: rtl/rx_pkt_deframer_if.sv
// rx_pkt_deframer_if
//   Bundles the three handshakes around the receive deframer:
//     - flit input    : in_valid / in_ready / in_flit[39:0] = {vc, id[1:0], req[4:0], payload[31:0]}
//     - header output : hdr_valid / hdr_ready plus decoded fields and the raw header
//     - data output   : data_valid / data_ready / data_word / data_last
//     - error pulses  : err_fmt, err_tag
//   Modports:
//     slave  - the deframer itself (consumes flits, produces header/data/errors)
//     master - the surrounding logic (produces flits, consumes header/data)
interface rx_pkt_deframer_if;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_flit;

  logic        hdr_valid;
  logic        hdr_ready;
  logic [3:0]  hdr_fmt;
  logic [4:0]  hdr_dest;
  logic [4:0]  hdr_req;
  logic [1:0]  hdr_id;
  logic        hdr_vc;
  logic [29:0] hdr_addr;
  logic [7:0]  hdr_len;
  logic [63:0] hdr_raw;

  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_word;
  logic        data_last;

  logic        err_fmt;
  logic        err_tag;

  modport slave (
    input  in_valid, in_flit, hdr_ready, data_ready,
    output in_ready,
    output hdr_valid, hdr_fmt, hdr_dest, hdr_req, hdr_id, hdr_vc, hdr_addr, hdr_len, hdr_raw,
    output data_valid, data_word, data_last,
    output err_fmt, err_tag
  );

  modport master (
    output in_valid, in_flit, hdr_ready, data_ready,
    input  in_ready,
    input  hdr_valid, hdr_fmt, hdr_dest, hdr_req, hdr_id, hdr_vc, hdr_addr, hdr_len, hdr_raw,
    input  data_valid, data_word, data_last,
    input  err_fmt, err_tag
  );
endinterface

// File: rtl/rx_pkt_deframer.sv
// rx_pkt_deframer
//   Receive-side deframer. Collects a 1- or 2-word packet header from the flit
//   stream, presents the decoded header on a registered valid/ready handshake,
//   then passes the packet's payload words straight through with a last marker
//   derived from the header length. Flags bad format codes and route-tag
//   (vc/id/req) changes inside a packet with registered one-cycle pulses.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - rx_pkt_deframer_if.slave (flit in, header out, data out, errors)
module rx_pkt_deframer (
  input  logic             clk,
  input  logic             rst,
  rx_pkt_deframer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR1 = 2'd1,
    HOUT = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam logic [3:0] FMT_LONG_READ   = 4'd0;
  localparam logic [3:0] FMT_LONG_WRITE  = 4'd1;
  localparam logic [3:0] FMT_MEM_RESP    = 4'd2;
  localparam logic [3:0] FMT_MSG         = 4'd3;
  localparam logic [3:0] FMT_SHORT_READ  = 4'd5;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'd6;
  localparam logic [3:0] FMT_LAST_VALID  = 4'd6;

  state_t      state_r;
  logic [8:0]  cnt_r;
  logic [7:0]  tags_r;      // {vc, id, req} of the packet's first flit
  logic        hdr_valid_r;
  logic [3:0]  hdr_fmt_r;
  logic [4:0]  hdr_dest_r;
  logic [29:0] hdr_addr_r;
  logic [7:0]  hdr_len_r;
  logic [63:0] hdr_raw_r;
  logic        err_fmt_r;
  logic        err_tag_r;

  logic [7:0]  flit_tags_s;
  logic [31:0] flit_word_s;
  logic [3:0]  flit_fmt_s;
  logic        tag_diff_s;
  logic        in_ready_s;
  logic        data_valid_s;
  logic [31:0] data_word_s;
  logic        data_last_s;

  // Payload word count carried by a packet; 0 in the 7-bit field encodes 128,
  // 0 in the 4-bit field encodes 16, and read/config formats carry none.
  function automatic logic [7:0] payload_len(input logic [3:0] fmt, input logic [6:0] len7);
    logic [7:0] len;
    case (fmt)
      FMT_LONG_WRITE, FMT_MEM_RESP, FMT_MSG:
        len = (len7 == 7'd0) ? 8'd128 : {1'b0, len7};
      FMT_SHORT_WRITE:
        len = (len7[3:0] == 4'd0) ? 8'd16 : {4'd0, len7[3:0]};
      default:
        len = 8'd0;
    endcase
    return len;
  endfunction

  // Word address known from the first header word: only short formats carry one.
  function automatic logic [29:0] first_word_addr(input logic [3:0] fmt, input logic [18:0] addr19);
    logic [29:0] addr;
    case (fmt)
      FMT_SHORT_READ, FMT_SHORT_WRITE: addr = {11'd0, addr19};
      default:                         addr = 30'd0;
    endcase
    return addr;
  endfunction

  assign flit_tags_s = bus.in_flit[39:32];
  assign flit_word_s = bus.in_flit[31:0];
  assign flit_fmt_s  = flit_word_s[31:28];
  assign tag_diff_s  = (flit_tags_s != tags_r);

  // Input readiness and the zero-latency data pass-through; in_ready never
  // depends on in_valid, only on state and the downstream data_ready.
  always_comb begin
    in_ready_s   = 1'b0;
    data_valid_s = 1'b0;
    data_word_s  = 32'd0;
    data_last_s  = 1'b0;
    case (state_r)
      IDLE, HDR1: begin
        in_ready_s = 1'b1;
      end
      HOUT: begin
        in_ready_s = 1'b0;
      end
      DATA: begin
        in_ready_s   = bus.data_ready;
        data_valid_s = bus.in_valid;
        data_word_s  = flit_word_s;
        data_last_s  = (cnt_r == 9'd1);
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Packet state machine: header assembly, header handshake, payload count and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 9'd0;
      tags_r      <= 8'd0;
      hdr_valid_r <= 1'b0;
      hdr_fmt_r   <= 4'd0;
      hdr_dest_r  <= 5'd0;
      hdr_addr_r  <= 30'd0;
      hdr_len_r   <= 8'd0;
      hdr_raw_r   <= 64'd0;
      err_fmt_r   <= 1'b0;
      err_tag_r   <= 1'b0;
    end else begin
      err_fmt_r <= 1'b0;
      err_tag_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            if (flit_fmt_s > FMT_LAST_VALID) begin
              // Unknown format: the flit is consumed and dropped.
              err_fmt_r <= 1'b1;
            end else begin
              tags_r     <= flit_tags_s;
              hdr_fmt_r  <= flit_fmt_s;
              hdr_dest_r <= flit_word_s[27:23];
              hdr_addr_r <= first_word_addr(flit_fmt_s, flit_word_s[22:4]);
              hdr_len_r  <= payload_len(flit_fmt_s, flit_word_s[6:0]);
              hdr_raw_r  <= {flit_word_s, 32'd0};
              if ((flit_fmt_s == FMT_LONG_READ) || (flit_fmt_s == FMT_LONG_WRITE)) begin
                state_r <= HDR1;
              end else begin
                hdr_valid_r <= 1'b1;
                state_r     <= HOUT;
              end
            end
          end
        end
        HDR1: begin
          if (bus.in_valid) begin
            hdr_raw_r[31:0] <= flit_word_s;
            hdr_addr_r      <= flit_word_s[31:2];
            err_tag_r       <= tag_diff_s;
            hdr_valid_r     <= 1'b1;
            state_r         <= HOUT;
          end
        end
        HOUT: begin
          if (bus.hdr_ready) begin
            hdr_valid_r <= 1'b0;
            cnt_r       <= {1'b0, hdr_len_r};
            state_r     <= (hdr_len_r == 8'd0) ? IDLE : DATA;
          end
        end
        DATA: begin
          if (bus.in_valid && bus.data_ready) begin
            cnt_r     <= cnt_r - 9'd1;
            err_tag_r <= tag_diff_s;
            if (cnt_r == 9'd1) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.hdr_valid  = hdr_valid_r;
  assign bus.hdr_fmt    = hdr_fmt_r;
  assign bus.hdr_dest   = hdr_dest_r;
  assign bus.hdr_req    = tags_r[4:0];
  assign bus.hdr_id     = tags_r[6:5];
  assign bus.hdr_vc     = tags_r[7];
  assign bus.hdr_addr   = hdr_addr_r;
  assign bus.hdr_len    = hdr_len_r;
  assign bus.hdr_raw    = hdr_raw_r;
  assign bus.data_valid = data_valid_s;
  assign bus.data_word  = data_word_s;
  assign bus.data_last  = data_last_s;
  assign bus.err_fmt    = err_fmt_r;
  assign bus.err_tag    = err_tag_r;

endmodule

// File: tb/tb_rx_pkt_deframer.sv
// tb_rx_pkt_deframer
//   Randomized bench for rx_pkt_deframer. Packets are described at packet
//   level (format, dest, length field, address, optional tag flip); the
//   reference model turns each into the flits to send, the expected decoded
//   header, the expected payload words with their last marker, and the
//   expected error pulses. A single cycle task drives random valid/ready
//   patterns and scoreboards every handshake.
module tb_rx_pkt_deframer;

  localparam int K_DATA = 0;  // payload flit
  localparam int K_HDR0 = 1;  // first word of a 2-word header
  localparam int K_HDRL = 2;  // final header word
  localparam int K_BAD  = 3;  // invalid format flit

  typedef struct {
    logic [39:0] flit;
    int          kind;
    bit          bad_tag;
  } flit_t;

  typedef struct {
    logic [3:0]  fmt;
    logic [4:0]  dest;
    logic [4:0]  req;
    logic [1:0]  id;
    logic        vc;
    logic [29:0] addr;
    logic [7:0]  len;
    logic [63:0] raw;
  } hdr_t;

  typedef struct {
    logic [31:0] word;
    bit          last;
  } dword_t;

  logic clk = 1'b0;
  logic rst;

  rx_pkt_deframer_if bus ();

  rx_pkt_deframer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  flit_t  tx_q[$];
  hdr_t   hdr_q[$];
  dword_t data_q[$];

  int n_checks = 0;
  int n_errors = 0;

  bit exp_errfmt, exp_errtag, exp_hv, exp_hdr1, exp_ready;
  bit phase_data;
  bit hv_hold;
  logic [54:0] prev_fields;
  logic [63:0] prev_raw;
  int hv_cycles;
  int hold_target;
  int valid_pct;
  int ready_pct;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: packet description -> flits, expected header, payload, errors.
  task automatic build_pkt(input logic [3:0] fmt, input logic [4:0] dest, input logic [6:0] lenf,
                           input logic [29:0] addr, input int flip_at);
    logic [7:0]  tags;
    logic [7:0]  mask;
    logic [15:0] fill;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          is_long;
    int          nwords;
    int          base;
    hdr_t        h;
    flit_t       f;
    dword_t      d;
    tags    = 8'($urandom);
    mask    = 8'($urandom_range(1, 255));
    fill    = 16'($urandom);
    w1      = {addr, 2'($urandom)};
    is_long = (fmt == 4'd0) || (fmt == 4'd1);
    if ((fmt == 4'd5) || (fmt == 4'd6)) w0 = {fmt, dest, addr[18:0], lenf[3:0]};
    else                                w0 = {fmt, dest, fill, lenf};
    if (fmt > 4'd6) begin
      f.flit = {tags, w0}; f.kind = K_BAD; f.bad_tag = 1'b0;
      tx_q.push_back(f);
      return;
    end
    nwords = 0;
    if ((fmt == 4'd1) || (fmt == 4'd2) || (fmt == 4'd3)) nwords = (lenf == 7'd0) ? 128 : int'(lenf);
    if (fmt == 4'd6) nwords = (lenf[3:0] == 4'd0) ? 16 : int'(lenf[3:0]);
    h.fmt  = fmt;
    h.dest = dest;
    h.req  = tags[4:0];
    h.id   = tags[6:5];
    h.vc   = tags[7];
    h.len  = 8'(nwords);
    if (is_long)                             h.addr = addr;
    else if ((fmt == 4'd5) || (fmt == 4'd6)) h.addr = {11'd0, addr[18:0]};
    else                                     h.addr = 30'd0;
    h.raw = is_long ? {w0, w1} : {w0, 32'd0};
    hdr_q.push_back(h);
    // Flit 0 is never checked against itself, so a flip there only changes the tags.
    f.flit = {(flip_at == 0) ? (tags ^ mask) : tags, w0};
    f.kind = is_long ? K_HDR0 : K_HDRL;
    f.bad_tag = 1'b0;
    if (flip_at == 0) begin
      h = hdr_q.pop_back();
      h.req = f.flit[36:32]; h.id = f.flit[38:37]; h.vc = f.flit[39];
      hdr_q.push_back(h);
      tags = f.flit[39:32];
    end
    tx_q.push_back(f);
    base = 1;
    if (is_long) begin
      f.flit = {(flip_at == 1) ? (tags ^ mask) : tags, w1};
      f.kind = K_HDRL; f.bad_tag = (flip_at == 1);
      tx_q.push_back(f);
      base = 2;
    end
    for (int k = 0; k < nwords; k++) begin
      d.word = 32'($urandom);
      d.last = (k == nwords - 1);
      data_q.push_back(d);
      f.flit = {(flip_at == base + k) ? (tags ^ mask) : tags, d.word};
      f.kind = K_DATA; f.bad_tag = (flip_at == base + k);
      tx_q.push_back(f);
    end
  endtask

  // One clock cycle: check registered consequences of the last edge, drive
  // new inputs, then sample handshakes and scoreboard at the falling edge.
  task automatic step();
    flit_t  f;
    hdr_t   h;
    bit     acc, hs, dx;
    @(posedge clk);
    #1;
    if (exp_errfmt || (bus.err_fmt !== 1'b0)) check("err_fmt", 64'(bus.err_fmt), 64'(exp_errfmt));
    if (exp_errtag || (bus.err_tag !== 1'b0)) check("err_tag", 64'(bus.err_tag), 64'(exp_errtag));
    if (exp_hv) check("hdr_latency", 64'(bus.hdr_valid), 64'd1);
    if (exp_hdr1) begin
      check("hdr1_no_valid", 64'(bus.hdr_valid), 64'd0);
      check("hdr1_in_ready", 64'(bus.in_ready), 64'd1);
    end
    if (exp_ready) check("ready_after_pkt", 64'(bus.in_ready), 64'd1);
    exp_errfmt = 1'b0; exp_errtag = 1'b0; exp_hv = 1'b0; exp_hdr1 = 1'b0; exp_ready = 1'b0;

    if ((tx_q.size() > 0) && ($urandom_range(0, 99) < valid_pct)) begin
      bus.in_valid = 1'b1;
      bus.in_flit  = tx_q[0].flit;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_flit  = {8'($urandom), 32'($urandom)};
    end
    if (bus.hdr_valid) begin
      bus.hdr_ready = (hv_cycles >= hold_target);
      hv_cycles++;
    end else begin
      hv_cycles     = 0;
      bus.hdr_ready = 1'($urandom_range(0, 1));
    end
    bus.data_ready = ($urandom_range(0, 99) < ready_pct);

    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    hs  = bus.hdr_valid && bus.hdr_ready;
    dx  = bus.data_valid && bus.data_ready;

    if (bus.hdr_valid) check("hout_in_ready", 64'(bus.in_ready), 64'd0);
    if (bus.hdr_valid && hv_hold) begin
      check("hdr_stable_fields", 64'({bus.hdr_fmt, bus.hdr_dest, bus.hdr_req, bus.hdr_id, bus.hdr_vc,
                                      bus.hdr_addr, bus.hdr_len}), 64'(prev_fields));
      check("hdr_stable_raw", bus.hdr_raw, prev_raw);
    end
    if (phase_data) begin
      check("data_valid", 64'(bus.data_valid), 64'(bus.in_valid));
      if (bus.data_valid) begin
        if (data_q.size() == 0) begin
          check("data_extra", 64'd1, 64'd0);
        end else begin
          check("data_word", 64'(bus.data_word), 64'(data_q[0].word));
          check("data_last", 64'(bus.data_last), 64'(data_q[0].last));
        end
      end
    end else begin
      check("data_idle", 64'({bus.data_valid, bus.data_last, bus.data_word}), 64'd0);
    end

    if (hs) begin
      if (hdr_q.size() == 0) begin
        check("hdr_extra", 64'd1, 64'd0);
      end else begin
        h = hdr_q.pop_front();
        check("hdr_fmt",  64'(bus.hdr_fmt),  64'(h.fmt));
        check("hdr_dest", 64'(bus.hdr_dest), 64'(h.dest));
        check("hdr_req",  64'(bus.hdr_req),  64'(h.req));
        check("hdr_id",   64'(bus.hdr_id),   64'(h.id));
        check("hdr_vc",   64'(bus.hdr_vc),   64'(h.vc));
        check("hdr_addr", 64'(bus.hdr_addr), 64'(h.addr));
        check("hdr_len",  64'(bus.hdr_len),  64'(h.len));
        check("hdr_raw",  bus.hdr_raw,       h.raw);
        if (h.len != 8'd0) phase_data = 1'b1;
        else               exp_ready  = 1'b1;
      end
      hold_target = $urandom_range(0, 3);
    end
    if (dx && (data_q.size() > 0)) begin
      if (data_q[0].last) begin
        phase_data = 1'b0;
        exp_ready  = 1'b1;
      end
      void'(data_q.pop_front());
    end
    if (acc) begin
      f = tx_q.pop_front();
      exp_errfmt = (f.kind == K_BAD);
      exp_errtag = f.bad_tag;
      exp_hv     = (f.kind == K_HDRL);
      exp_hdr1   = (f.kind == K_HDR0);
    end
    hv_hold     = bus.hdr_valid && !hs;
    prev_fields = {bus.hdr_fmt, bus.hdr_dest, bus.hdr_req, bus.hdr_id, bus.hdr_vc, bus.hdr_addr, bus.hdr_len};
    prev_raw    = bus.hdr_raw;
  endtask

  task automatic run_until_done(input int budget);
    int cyc;
    cyc = 0;
    while (((tx_q.size() > 0) || (hdr_q.size() > 0) || (data_q.size() > 0)) && (cyc < budget)) begin
      step();
      cyc++;
    end
    // Let the last registered consequences (error pulse, ready) be checked.
    step();
    step();
    if ((tx_q.size() > 0) || (hdr_q.size() > 0) || (data_q.size() > 0))
      check("timeout", 64'(tx_q.size() + hdr_q.size() + data_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_flit = 40'd0; bus.hdr_ready = 1'b0; bus.data_ready = 1'b0;
    exp_errfmt = 1'b0; exp_errtag = 1'b0; exp_hv = 1'b0; exp_hdr1 = 1'b0; exp_ready = 1'b0;
    phase_data = 1'b0; hv_hold = 1'b0; hv_cycles = 0; hold_target = 5;
    prev_fields = 55'd0; prev_raw = 64'd0;
    valid_pct = 80; ready_pct = 60;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",   64'(bus.in_ready),   64'd1);
    check("rst_hdr_valid",  64'(bus.hdr_valid),  64'd0);
    check("rst_data_valid", 64'(bus.data_valid), 64'd0);
    check("rst_errs",       64'({bus.err_fmt, bus.err_tag}), 64'd0);
    check("rst_hdr_len",    64'(bus.hdr_len),    64'd0);
    check("rst_hdr_raw",    bus.hdr_raw,         64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed packets from the plan; the first header is held off for 5 cycles.
    build_pkt(4'd6, 5'd3, 7'd2, 30'($urandom), -1);   // SHORT_WRITE len4=2
    build_pkt(4'd1, 5'($urandom), 7'd0, 30'($urandom), -1);   // LONG_WRITE 128 words
    build_pkt(4'd0, 5'($urandom), 7'd9, 30'($urandom), -1);   // LONG_READ, len field ignored
    build_pkt(4'd4, 5'($urandom), 7'd5, 30'($urandom), -1);   // SWITCH_CFG
    build_pkt(4'hA, 5'($urandom), 7'd3, 30'($urandom), -1);   // invalid format
    build_pkt(4'd3, 5'($urandom), 7'd1, 30'($urandom), -1);   // MSG len 1
    build_pkt(4'd2, 5'($urandom), 7'd3, 30'($urandom), 2);    // MEM_RESP, tag change on word 2
    build_pkt(4'd1, 5'($urandom), 7'd2, 30'($urandom), 1);    // tag change on header word 1
    run_until_done(5000);

    // Randomized traffic, including invalid formats and tag flips.
    for (int p = 0; p < 40; p++) begin
      logic [3:0] fmt;
      logic [6:0] lenf;
      int         flip;
      fmt  = 4'($urandom_range(0, 8));
      lenf = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 12));
      flip = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : -1;
      build_pkt(fmt, 5'($urandom), lenf, 30'($urandom), flip);
    end
    run_until_done(30000);

    // Reset in the middle of a payload.
    valid_pct = 100; ready_pct = 100;
    build_pkt(4'd3, 5'd7, 7'd10, 30'd0, -1);
    for (int c = 0; (c < 200) && (data_q.size() > 5); c++) step();
    check("pre_rst_in_data", 64'(phase_data), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready",   64'(bus.in_ready),   64'd1);
    check("midrst_hdr_valid",  64'(bus.hdr_valid),  64'd0);
    check("midrst_data_valid", 64'(bus.data_valid), 64'd0);
    check("midrst_errs",       64'({bus.err_fmt, bus.err_tag}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tx_q.delete(); hdr_q.delete(); data_q.delete();
    exp_errfmt = 1'b0; exp_errtag = 1'b0; exp_hv = 1'b0; exp_hdr1 = 1'b0; exp_ready = 1'b0;
    phase_data = 1'b0; hv_hold = 1'b0;
    valid_pct = 80; ready_pct = 50;
    build_pkt(4'd6, 5'd1, 7'd3, 30'($urandom), -1);
    build_pkt(4'd5, 5'd2, 7'd4, 30'($urandom), -1);
    run_until_done(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rx_pkt_deframer.md
# rx_pkt_deframer

Receive-side deframer between the flit-level link and the endpoint request/response logic. It accepts a stream of 40-bit flits {vc, id[1:0], req[4:0], payload[31:0]} and reassembles each packet's 1- or 2-word header into decoded fields presented on a header handshake. It then forwards the packet's payload words on a data handshake, with a last marker generated from the header length field. It also detects malformed traffic: bad format codes and route-tag changes inside a packet.

## Interface
- No parameters. Flit width is 40 bits and word width is 32 bits, both fixed by the chiplet types package.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  a flit is offered.
- in_ready  out  1  the block accepts the offered flit this cycle.
- in_flit  in  40  flit: [39] vc, [38:37] id, [36:32] req, [31:0] payload.
- hdr_valid  out  1  decoded header is available.
- hdr_ready  in  1  consumer accepts the header.
- hdr_fmt  out  4  format code.
- hdr_dest  out  5  destination node.
- hdr_req  out  5  request tag from the first flit.
- hdr_id  out  2  id tag from the first flit.
- hdr_vc  out  1  vc from the first flit.
- hdr_addr  out  30  word address; short formats zero-extend addr[18:0]; message, response and switch-config formats drive 0.
- hdr_len  out  8  payload word count, 0..128.
- hdr_raw  out  64  raw header: {word0, word1}, with word1 = 0 for 1-word headers.
- data_valid  out  1  payload word is available.
- data_ready  in  1  consumer accepts the payload word.
- data_word  out  32  payload word.
- data_last  out  1  final payload word of the packet.
- err_fmt  out  1  one-cycle pulse: an invalid format code was received.
- err_tag  out  1  one-cycle pulse: vc, id or req changed inside a packet.

## Operation
Format codes: 0 LONG_READ, 1 LONG_WRITE, 2 MEM_RESP, 3 MSG, 4 SWITCH_CFG, 5 SHORT_READ, 6 SHORT_WRITE. Codes 7–15 are invalid.

Format is payload[31:28] and dest is payload[27:23] of the first flit.

Header length and payload length by format:
- Long formats use a 2-word header. Word0 holds fmt, dest, r0, lst_b, fst_b and len7 = word0[6:0]. Address = word1[31:2].
- SHORT_*: 1-word header; addr19 = [22:4], len4 = [3:0].
- MSG and MEM_RESP: 1-word header; len7 = [6:0].
- SWITCH_CFG: 1-word header, no payload.

Payload length rules:
- LONG_WRITE, MEM_RESP and MSG carry len7 payload words; a value of 0 encodes 128.
- SHORT_WRITE carries len4 payload words; a value of 0 encodes 16.
- LONG_READ, SHORT_READ and SWITCH_CFG carry no payload, so hdr_len = 0 regardless of the length field.

State machine (reset state is IDLE):
- IDLE: in_ready = 1.
  - Invalid format: pulse err_fmt, drop the flit, stay in IDLE.
  - Long format: latch word0 and the tags, go to HDR1.
  - Any other valid format: latch, go to HOUT.
- HDR1: in_ready = 1. Latch word1 on accept, then go to HOUT. If the flit's tags differ from the latched tags, pulse err_tag; the header is still completed.
- HOUT: hdr_valid = 1, in_ready = 0. On hdr_ready, load cnt = hdr_len (9-bit). If hdr_len = 0 go to IDLE, else go to DATA.
- DATA: combinational pass-through.
  - data_valid = in_valid, in_ready = data_ready, data_word = in_flit.payload, data_last = (cnt == 1).
  - On each transfer, cnt decrements. A transfer with data_last set returns to IDLE.
  - A tag mismatch pulses err_tag; the word is still forwarded.

Output behaviour:
- hdr_* fields are registered and held stable while hdr_valid is high.
- data_* outputs are 0 outside DATA.

## Timing
- Reset values: all outputs are 0 except in_ready, which is 1 (IDLE). The counter and latched fields clear to 0.
- Header latency: hdr_valid rises the cycle after the last header flit is accepted.
- Back-to-back packets:
  - No bubble on the input side except the HOUT cycle(s).
  - After the last data transfer, the next flit can be accepted on the following cycle.
  - A zero-payload header returns the block to IDLE the cycle after the hdr handshake.
- Data path: zero-cycle pass-through, with no combinational path from in_valid to in_ready.
- Error pulses are registered: they assert for exactly one cycle, the cycle after the offending flit is accepted.
- Reset asserted mid-packet returns the block to IDLE immediately. Any partial packet is discarded with no error pulse.
- Simultaneous hdr_ready and in_valid in HOUT: the flit is not accepted (in_ready = 0).

## Test plan
- SHORT_WRITE, dest 3, len4 = 2, then 2 data words:
  - Header: hdr_fmt = 6, hdr_len = 2, addr zero-extended.
  - data_last on word 2.
  - in_ready high again the next cycle.
- LONG_WRITE, len7 = 0:
  - hdr_len = 128.
  - Exactly 128 data transfers; data_last only on the 128th; cnt ends at 0.
- LONG_READ (2 header words) followed directly by SWITCH_CFG:
  - Two hdr handshakes, each with hdr_len = 0, and no data_valid.
  - hdr_addr = word1[31:2] for the LONG_READ.
- Invalid format 0xA flit:
  - err_fmt pulses for 1 cycle, no hdr_valid.
  - A following valid MSG (len7 = 1) decodes correctly.
- MEM_RESP, len 3, with the req tag changed on data word 2: err_tag pulses once and all 3 words are still forwarded.
- Backpressure and reset:
  - hdr_ready held low for 5 cycles: hdr fields stable and in_ready = 0 throughout.
  - data_ready toggled: no word lost or duplicated.
  - rst asserted mid-DATA: IDLE is entered with in_ready = 1.
